vga_blit_master: RTL and testbench
==================================

Name: vga_blit_master

Overview:
- Wishbone classic initiator that copies a sprite from a synchronous sprite ROM into the VGA back frame buffer.
- For each pixel it writes the frame-buffer pixel-address register, then the pixel-data register.
- Sits between the game-control logic (start/coordinates) and the VGA frame-buffer slave on the SoC bus.
- Frees the CPU from per-pixel register traffic.

Parameters:
- VGA_BASE, 32'h0000_0000, byte base address of VGA register block; regs at +0x0 frame select, +0x4 pixel address, +0xC pixel data.
- SCREEN_W, 320, frame-buffer width in pixels.
- SCREEN_H, 240, frame-buffer height in pixels.
- KEY_COLOR, 12'h000, transparent colour; matching pixels are not written.

Ports:
- clk  in  1  system/bus clock
- wb_rst_i  in  1  reset
- start  in  1  one-cycle pulse; begin blit (ignored while busy)
- pos_x  in  9  sprite left column, sampled on start
- pos_y  in  8  sprite top row, sampled on start
- spr_w  in  5  sprite width 0..16, sampled on start
- spr_h  in  5  sprite height 0..16, sampled on start
- flip_val  in  1  value written to frame select at end (feature only)
- rom_addr  out  8  sprite ROM address {row[3:0],col[3:0]}
- rom_data  in  12  ROM data, valid 1 cycle after rom_addr
- busy  out  1  blit in progress
- done  out  1  one-cycle pulse at completion
- err  out  1  sticky; set on wb_err_i, cleared on next accepted start
- pix_count  out  9  pixels written by last blit
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone control
- wb_adr_o  out  32  address
- wb_dat_o  out  32  write data
- wb_sel_o  out  4  byte select, constant 4'hF
- wb_dat_i  in  32  read data (unused)
- wb_ack_i, wb_err_i  in  1 each  termination

Behaviour:
- Reset is wb_rst_i, asynchronous, active-high; clock is clk.
- Reset values: all outputs 0 except wb_sel_o=4'hF; state IDLE.
- States:
  - IDLE: on start, latch inputs, clear col/row/pix_count/err, assert busy. If spr_w==0 or spr_h==0, go to DONE; else go to FETCH.
  - FETCH: drive rom_addr; go to CHECK next cycle.
  - CHECK: compute px=pos_x+col, py=pos_y+row (10-bit, no wrap). If rom_data==KEY_COLOR or px>=SCREEN_W or py>=SCREEN_H, go to NEXT. Else latch colour and go to WR_ADDR.
  - WR_ADDR: cyc=stb=we=1, adr=VGA_BASE+4, dat={15'b0, py*SCREEN_W+px} (17-bit). Hold until ack, then drop cyc/stb/we in the same cycle ack is sampled and go to WR_DATA.
  - WR_DATA: as WR_ADDR but adr=VGA_BASE+0xC, dat={20'b0,colour}. On ack, increment pix_count and go to NEXT.
  - NEXT: col++. If col==spr_w, set col=0 and row++. If row==spr_h, go to FLIP (feature) or DONE; else go to FETCH.
  - DONE: pulse done for 1 cycle, clear busy, go to IDLE.
- Bus outputs are registered and stable while stb is high. At least one idle cycle (cyc=0) separates consecutive transactions. The bench must tolerate any number of wait states.
- wb_err_i during any bus state: drop cyc/stb, set err, abandon the blit, go to DONE.
- start while busy is ignored.
- Reset mid-transaction drops cyc/stb asynchronously; no further writes occur.
- Fully off-screen sprite: zero bus transactions, done still pulses, pix_count=0.

Optional Feature:
- Macro VGA_BLIT_FLIP_EN.
- Defined: after the last pixel, state FLIP writes adr=VGA_BASE+0, dat={31'b0,flip_val}, waits for ack, then goes to DONE. Error handling is the same as for other bus states.
- Undefined: the FLIP state and the flip_val logic are absent, and flip_val is ignored.

Test Plan:
- 2x2 sprite, all 12'hABC, pos (10,5), ack after 1 wait: writes adr +4 dat 1610, +C dat ABC, then 1611, 1930, 1931 in order; pix_count=4; done pulses once.
- 16x16 sprite with ROM pixel 0 = KEY_COLOR, pos (0,0): 255 pixel pairs; address 0 is never written.
- pos (318,239), 4x4 all non-key: only pixels (318,239) and (319,239) are written (addresses 76798, 76799); pix_count=2.
- spr_w=0: no cyc assertion; done pulses 2 cycles after start.
- wb_err_i on the 3rd transaction: cyc drops, err=1, done pulses; the next start clears err.
- With VGA_BLIT_FLIP_EN and flip_val=1: the final transaction is adr VGA_BASE+0, dat 1, issued after the last pixel data write.

Source files
------------

// File: rtl/vga_blit_master.sv
// vga_blit_master: Wishbone classic initiator that copies a sprite from a
// synchronous sprite ROM into the VGA back frame buffer. Each visible pixel
// whose colour is not the transparent key costs two single writes: the
// pixel-address register, then the pixel-data register.
// Optional feature macro: VGA_BLIT_FLIP_EN -- after the last pixel the
// master writes flip_val to the frame-select register before signalling done.
module vga_blit_master #(
    parameter logic [31:0] VGA_BASE  = 32'h0000_0000,
    parameter int          SCREEN_W  = 320,
    parameter int          SCREEN_H  = 240,
    parameter logic [11:0] KEY_COLOR = 12'h000
) (
    input  logic        clk,
    input  logic        wb_rst_i,
    input  logic        start,
    input  logic [8:0]  pos_x,
    input  logic [7:0]  pos_y,
    input  logic [4:0]  spr_w,
    input  logic [4:0]  spr_h,
    input  logic        flip_val,
    output logic [7:0]  rom_addr,
    input  logic [11:0] rom_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [8:0]  pix_count,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

`ifdef VGA_BLIT_FLIP_EN
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_WR_ADDR = 3'd3,
        ST_WR_DATA = 3'd4,
        ST_NEXT    = 3'd5,
        ST_DONE    = 3'd6,
        ST_FLIP    = 3'd7
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_WR_ADDR = 3'd3,
        ST_WR_DATA = 3'd4,
        ST_NEXT    = 3'd5,
        ST_DONE    = 3'd6
    } state_t;
`endif

    state_t      state_r, state_nxt;
    logic [8:0]  pos_x_r, pos_x_nxt;
    logic [7:0]  pos_y_r, pos_y_nxt;
    logic [4:0]  spr_w_r, spr_w_nxt;
    logic [4:0]  spr_h_r, spr_h_nxt;
    logic [4:0]  col_r, col_nxt;
    logic [4:0]  row_r, row_nxt;
    logic [11:0] colour_r, colour_nxt;
    logic [16:0] pix_addr_r, pix_addr_nxt;
    logic [8:0]  pix_count_r, pix_count_nxt;
    logic        err_r, err_nxt;
    logic        busy_r, busy_nxt;
    logic        done_r, done_nxt;
    logic        cyc_r, cyc_nxt;
    logic [31:0] adr_r, adr_nxt;
    logic [31:0] dat_r, dat_nxt;
    logic [7:0]  rom_addr_r, rom_addr_nxt;

    // Per-state bus request, shared by every state that issues a write
    logic        bus_st_s;
    logic        bus_cnt_s;
    logic [31:0] bus_adr_s;
    logic [31:0] bus_dat_s;
    state_t      bus_next_s;

    // Screen coordinates of the current sprite pixel (10 bits, never wraps)
    logic [9:0]  px_s;
    logic [9:0]  py_s;
    logic [16:0] lin_s;
    logic        on_screen_s;
    logic [4:0]  col_inc_s;
    logic [4:0]  row_inc_s;

    // Read data and (in the default build) flip_val have no consumer
    logic        unused_s;

    assign unused_s    = ^{wb_dat_i, flip_val};
    assign px_s        = {1'b0, pos_x_r} + {5'b0_0000, col_r};
    assign py_s        = {2'b00, pos_y_r} + {5'b0_0000, row_r};
    assign lin_s       = 17'(py_s) * 17'(SCREEN_W) + 17'(px_s);
    assign on_screen_s = (px_s < 10'(SCREEN_W)) && (py_s < 10'(SCREEN_H));
    assign col_inc_s   = col_r + 5'd1;
    assign row_inc_s   = row_r + 5'd1;

    // Next-state and next-output logic for the blit sequencer
    always_comb begin
        state_nxt     = state_r;
        pos_x_nxt     = pos_x_r;
        pos_y_nxt     = pos_y_r;
        spr_w_nxt     = spr_w_r;
        spr_h_nxt     = spr_h_r;
        col_nxt       = col_r;
        row_nxt       = row_r;
        colour_nxt    = colour_r;
        pix_addr_nxt  = pix_addr_r;
        pix_count_nxt = pix_count_r;
        err_nxt       = err_r;
        busy_nxt      = busy_r;
        done_nxt      = 1'b0;
        cyc_nxt       = 1'b0;
        adr_nxt       = adr_r;
        dat_nxt       = dat_r;
        bus_st_s      = 1'b0;
        bus_cnt_s     = 1'b0;
        bus_adr_s     = VGA_BASE;
        bus_dat_s     = 32'h0000_0000;
        bus_next_s    = ST_DONE;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    pos_x_nxt     = pos_x;
                    pos_y_nxt     = pos_y;
                    spr_w_nxt     = spr_w;
                    spr_h_nxt     = spr_h;
                    col_nxt       = 5'd0;
                    row_nxt       = 5'd0;
                    pix_count_nxt = 9'd0;
                    err_nxt       = 1'b0;
                    busy_nxt      = 1'b1;
                    if ((spr_w == 5'd0) || (spr_h == 5'd0)) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_FETCH;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if ((rom_data == KEY_COLOR) || !on_screen_s) begin
                    state_nxt = ST_NEXT;
                end else begin
                    colour_nxt   = rom_data;
                    pix_addr_nxt = lin_s;
                    state_nxt    = ST_WR_ADDR;
                end
            end
            ST_WR_ADDR: begin
                bus_st_s   = 1'b1;
                bus_adr_s  = VGA_BASE + 32'h0000_0004;
                bus_dat_s  = {15'b0, pix_addr_r};
                bus_next_s = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                bus_st_s   = 1'b1;
                bus_cnt_s  = 1'b1;
                bus_adr_s  = VGA_BASE + 32'h0000_000C;
                bus_dat_s  = {20'b0, colour_r};
                bus_next_s = ST_NEXT;
            end
            ST_NEXT: begin
                if (col_inc_s == spr_w_r) begin
                    col_nxt = 5'd0;
                    row_nxt = row_inc_s;
                    if (row_inc_s == spr_h_r) begin
`ifdef VGA_BLIT_FLIP_EN
                        state_nxt = ST_FLIP;
`else
                        state_nxt = ST_DONE;
`endif
                    end else begin
                        state_nxt = ST_FETCH;
                    end
                end else begin
                    col_nxt   = col_inc_s;
                    state_nxt = ST_FETCH;
                end
            end
`ifdef VGA_BLIT_FLIP_EN
            ST_FLIP: begin
                bus_st_s   = 1'b1;
                bus_adr_s  = VGA_BASE;
                bus_dat_s  = {31'b0, flip_val};
                bus_next_s = ST_DONE;
            end
`endif
            ST_DONE: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Single-write handshake: launch from an idle bus, then hold the
        // registered request until ack/err, dropping cyc on that very edge.
        // Entering each bus state with cyc low guarantees an idle cycle
        // between consecutive writes.
        if (bus_st_s) begin
            if (!cyc_r) begin
                cyc_nxt = 1'b1;
                adr_nxt = bus_adr_s;
                dat_nxt = bus_dat_s;
            end else if (wb_err_i) begin
                cyc_nxt   = 1'b0;
                err_nxt   = 1'b1;
                state_nxt = ST_DONE;
            end else if (wb_ack_i) begin
                cyc_nxt   = 1'b0;
                state_nxt = bus_next_s;
                if (bus_cnt_s) begin
                    pix_count_nxt = pix_count_r + 9'd1;
                end else begin
                    pix_count_nxt = pix_count_r;
                end
            end else begin
                cyc_nxt = 1'b1;
            end
        end else begin
            cyc_nxt = 1'b0;
        end

        rom_addr_nxt = {row_nxt[3:0], col_nxt[3:0]};
    end

    // State and registered-output update; reset also drops the bus at once
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r     <= ST_IDLE;
            pos_x_r     <= 9'd0;
            pos_y_r     <= 8'd0;
            spr_w_r     <= 5'd0;
            spr_h_r     <= 5'd0;
            col_r       <= 5'd0;
            row_r       <= 5'd0;
            colour_r    <= 12'h000;
            pix_addr_r  <= 17'd0;
            pix_count_r <= 9'd0;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cyc_r       <= 1'b0;
            adr_r       <= 32'h0000_0000;
            dat_r       <= 32'h0000_0000;
            rom_addr_r  <= 8'h00;
        end else begin
            state_r     <= state_nxt;
            pos_x_r     <= pos_x_nxt;
            pos_y_r     <= pos_y_nxt;
            spr_w_r     <= spr_w_nxt;
            spr_h_r     <= spr_h_nxt;
            col_r       <= col_nxt;
            row_r       <= row_nxt;
            colour_r    <= colour_nxt;
            pix_addr_r  <= pix_addr_nxt;
            pix_count_r <= pix_count_nxt;
            err_r       <= err_nxt;
            busy_r      <= busy_nxt;
            done_r      <= done_nxt;
            cyc_r       <= cyc_nxt;
            adr_r       <= adr_nxt;
            dat_r       <= dat_nxt;
            rom_addr_r  <= rom_addr_nxt;
        end
    end

    assign rom_addr  = rom_addr_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign pix_count = pix_count_r;
    assign wb_cyc_o  = cyc_r;
    assign wb_stb_o  = cyc_r;
    assign wb_we_o   = cyc_r;
    assign wb_adr_o  = adr_r;
    assign wb_dat_o  = dat_r;
    assign wb_sel_o  = 4'hF;

endmodule

// File: tb/tb_vga_blit_master.sv
// Self-checking bench for vga_blit_master: a table of sprite placements with
// hand-computed results, plus hand-written sequences for exact write order,
// zero-size timing, bus error, start-while-busy and reset mid-transaction.
module tb_vga_blit_master;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int NV = 11;
    localparam int LOGN = 2048;

    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  pos_x = 9'd0;
    logic [7:0]  pos_y = 8'd0;
    logic [4:0]  spr_w = 5'd0;
    logic [4:0]  spr_h = 5'd0;
    logic        flip_val = 1'b1;
    logic [7:0]  rom_addr;
    logic [11:0] rom_data = 12'h000;
    logic        busy, done, err;
    logic [8:0]  pix_count;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;

    vga_blit_master dut (
        .clk(clk), .wb_rst_i(wb_rst_i), .start(start),
        .pos_x(pos_x), .pos_y(pos_y), .spr_w(spr_w), .spr_h(spr_h),
        .flip_val(flip_val), .rom_addr(rom_addr), .rom_data(rom_data),
        .busy(busy), .done(done), .err(err), .pix_count(pix_count),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_dat_i(32'h0000_0000), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 clk = ~clk;

    // Synchronous sprite ROM
    logic [11:0] rom [0:255];
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Wishbone slave with programmable wait states and error injection,
    // plus transaction log and protocol/pulse monitors
    int slv_waits = 0;
    int slv_err_at = -1;
    int tx_n = 0, done_n = 0, cyc_n = 0, proto_n = 0, wcnt = 0;
    logic [31:0] hold_adr, hold_dat;
    logic [31:0] log_adr [0:LOGN-1];
    logic [31:0] log_dat [0:LOGN-1];

    always @(negedge clk) begin
        if (wb_rst_i) begin
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            wcnt = 0;
        end else if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i) begin
            if (wcnt == 0) begin
                hold_adr = wb_adr_o;
                hold_dat = wb_dat_o;
            end else if (wb_adr_o !== hold_adr || wb_dat_o !== hold_dat) begin
                proto_n++;
            end
            if (!wb_we_o || wb_sel_o !== 4'hF) proto_n++;
            if (wcnt == slv_waits) begin
                if (tx_n == slv_err_at) wb_err_i = 1'b1;
                else wb_ack_i = 1'b1;
                if (tx_n < LOGN) begin
                    log_adr[tx_n] = wb_adr_o;
                    log_dat[tx_n] = wb_dat_o;
                end
                tx_n++;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            if ((wb_ack_i || wb_err_i) && wb_cyc_o) proto_n++;
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
        end
        if (done) done_n++;
        if (wb_cyc_o) cyc_n++;
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fill_rom(input int mode);
        for (int i = 0; i < 256; i++) begin
            if (mode == 0) rom[i] = 12'hABC;
            else rom[i] = 12'h100 + 12'(i);
        end
        if (mode == 1) rom[0] = 12'h000;
    endtask

    function automatic int exp_col(input int mode, input int idx);
        if (mode == 0) return 12'hABC;
        return 12'h100 + idx;
    endfunction

    task automatic do_start(input int x, input int y, input int w, input int h);
        @(negedge clk);
        pos_x = 9'(x); pos_y = 8'(y); spr_w = 5'(w); spr_h = 5'(h);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int to);
        to = 1;
        for (int c = 0; c < 20000; c++) begin
            if (!busy) begin
                to = 0;
                break;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        int px, py, w, h, mode, waits, exp_pix, exp_first, exp_last;
    } vec_t;
    vec_t vecs [NV];

`ifdef VGA_BLIT_FLIP_EN
    localparam int FLIP = 1;
`else
    localparam int FLIP = 0;
`endif

    initial begin
        int tb0, db0, pb0, to, exp_tx, bad, prev, pa, prow, pcol, snap, csnap, found;
        int eadr [8];
        int edat [8];
        vec_t v;

        vecs[0]  = '{10, 5, 2, 2, 0, 1, 4, 1610, 1931};
        vecs[1]  = '{0, 0, 16, 16, 1, 0, 255, 1, 4815};
        vecs[2]  = '{318, 239, 4, 4, 2, 1, 2, 76798, 76799};
        vecs[3]  = '{0, 0, 0, 3, 2, 0, 0, 0, 0};
        vecs[4]  = '{320, 0, 4, 4, 2, 0, 0, 0, 0};
        vecs[5]  = '{0, 239, 3, 4, 2, 0, 3, 76480, 76482};
        vecs[6]  = '{5, 5, 5, 0, 2, 0, 0, 0, 0};
        vecs[7]  = '{100, 100, 1, 1, 2, 3, 1, 32100, 32100};
        vecs[8]  = '{305, 230, 16, 16, 2, 2, 150, 73905, 76799};
        vecs[9]  = '{0, 240, 2, 2, 2, 0, 0, 0, 0};
        vecs[10] = '{319, 0, 2, 1, 2, 0, 1, 319, 319};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst cyc", wb_cyc_o, 0);
        check("rst stb_we", {wb_stb_o, wb_we_o}, 0);
        check("rst adr_dat", wb_adr_o | wb_dat_o, 0);
        check("rst sel", wb_sel_o, 4'hF);
        check("rst busy_done_err", {busy, done, err}, 0);
        check("rst pix_count", pix_count, 0);
        check("rst rom_addr", rom_addr, 0);
        wb_rst_i = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven placements
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            fill_rom(v.mode);
            slv_waits = v.waits;
            slv_err_at = -1;
            tb0 = tx_n; db0 = done_n; pb0 = proto_n;
            do_start(v.px, v.py, v.w, v.h);
            wait_done(to);
            check($sformatf("v%0d timeout", i), to, 0);
            check($sformatf("v%0d pix_count", i), pix_count, v.exp_pix);
            exp_tx = 2 * v.exp_pix + ((v.w != 0 && v.h != 0) ? FLIP : 0);
            check($sformatf("v%0d tx_count", i), tx_n - tb0, exp_tx);
            check($sformatf("v%0d done_pulses", i), done_n - db0, 1);
            check($sformatf("v%0d err_busy", i), {err, busy}, 0);
            check($sformatf("v%0d protocol", i), proto_n - pb0, 0);
            if (v.exp_pix > 0) begin
                check($sformatf("v%0d first_pa", i), log_dat[tb0], v.exp_first);
                check($sformatf("v%0d last_pa", i), log_dat[tb0 + 2 * (v.exp_pix - 1)], v.exp_last);
                bad = 0;
                prev = -1;
                for (int k = 0; k < v.exp_pix; k++) begin
                    pa = int'(log_dat[tb0 + 2 * k]);
                    prow = pa / 320 - v.py;
                    pcol = pa % 320 - v.px;
                    if (log_adr[tb0 + 2 * k] !== BASE + 32'd4 ||
                        log_adr[tb0 + 2 * k + 1] !== BASE + 32'd12 ||
                        pa <= prev || prow < 0 || prow >= v.h || pcol < 0 || pcol >= v.w ||
                        int'(log_dat[tb0 + 2 * k + 1]) != exp_col(v.mode, prow * 16 + pcol))
                        bad++;
                    prev = pa;
                end
                check($sformatf("v%0d write_stream", i), bad, 0);
            end
        end

        // Exact write order for the 2x2 sprite at (10,5)
        eadr = '{4, 12, 4, 12, 4, 12, 4, 12};
        edat = '{1610, 'hABC, 1611, 'hABC, 1930, 'hABC, 1931, 'hABC};
        fill_rom(0);
        slv_waits = 1;
        tb0 = tx_n;
        do_start(10, 5, 2, 2);
        wait_done(to);
        check("seq timeout", to, 0);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("seq adr%0d", k), log_adr[tb0 + k], BASE + 32'(eadr[k]));
            check($sformatf("seq dat%0d", k), log_dat[tb0 + k], edat[k]);
        end
`ifdef VGA_BLIT_FLIP_EN
        check("flip adr", log_adr[tb0 + 8], BASE);
        check("flip dat", log_dat[tb0 + 8], 1);
`endif

        // Zero width: done two cycles after start, no bus cycle
        csnap = cyc_n;
        do_start(0, 0, 0, 4);
        check("w0 busy_t1", {busy, done}, 2'b10);
        @(negedge clk);
        check("w0 done_t2", {busy, done}, 2'b01);
        @(negedge clk);
        check("w0 done_t3", done, 0);
        check("w0 no_cyc", cyc_n - csnap, 0);

        // Bus error on the third transaction
        slv_waits = 1;
        tb0 = tx_n; db0 = done_n;
        slv_err_at = tx_n + 2;
        do_start(10, 5, 2, 2);
        wait_done(to);
        check("err timeout", to, 0);
        check("err flag", err, 1);
        check("err tx_count", tx_n - tb0, 3);
        check("err pix_count", pix_count, 1);
        check("err done_pulses", done_n - db0, 1);
        check("err cyc", wb_cyc_o, 0);
        slv_err_at = -1;
        do_start(0, 0, 0, 1);
        check("err cleared", err, 0);
        wait_done(to);

        // Start while busy is ignored
        slv_waits = 5;
        tb0 = tx_n; db0 = done_n;
        do_start(10, 5, 2, 2);
        repeat (10) @(negedge clk);
        pos_x = 9'd0; pos_y = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(to);
        check("busy_start tx_count", tx_n - tb0, 8 + FLIP);
        check("busy_start first_pa", log_dat[tb0], 1610);
        check("busy_start done_pulses", done_n - db0, 1);

        // Reset mid-transaction drops the bus asynchronously
        slv_waits = 6;
        do_start(10, 5, 2, 2);
        found = 0;
        for (int c = 0; c < 200; c++) begin
            if (wb_cyc_o) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("rst_mid cyc_seen", found, 1);
        #2 wb_rst_i = 1'b1;
        #1;
        check("rst_mid cyc_stb", {wb_cyc_o, wb_stb_o}, 0);
        check("rst_mid busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        wb_rst_i = 1'b0;
        snap = tx_n;
        csnap = cyc_n;
        repeat (60) @(negedge clk);
        check("rst_mid no_tx", tx_n - snap, 0);
        check("rst_mid no_cyc", cyc_n - csnap, 0);
        check("rst_mid pix_count", pix_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
